// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared types and helpers for the radix-2 shift-add
//               sequential multiplier (state encoding, operand magnitude).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int unsigned DEFAULT_WIDTH = 16;

    // Working width of the magnitude helper. Operands are zero-extended to
    // this width before use, so any WIDTH up to MAG_MAX_W/2 is supported.
    localparam int unsigned MAG_MAX_W = 64;

    // Controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Two's-complement magnitude of a zero-extended operand. When is_neg is
    // set the value is negated over the full working width; the low WIDTH
    // bits of the result are then the operand's magnitude. The most negative
    // operand maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [MAG_MAX_W-1:0] magnitude(
        input logic [MAG_MAX_W-1:0] value,
        input logic                 is_neg
    );
        magnitude = is_neg ? ((~value) + 64'd1) : value;
    endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_datapath
// Description : Shift-add datapath: multiplicand/multiplier shift registers,
//               accumulator and sign-fix negation, driven by load/step
//               strobes from the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_signed_mode,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_mplr_zero,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]        mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q,  mplr_d;
    logic [PW-1:0]        acc_q,   acc_d;
    logic                 neg_q,   neg_d;

    logic [MAG_MAX_W-1:0]       mag_a_full, mag_b_full;
    logic [MAG_MAX_W-WIDTH-1:0] mag_a_unused, mag_b_unused;
    logic [WIDTH-1:0]           mag_a, mag_b;

    // Operand magnitudes; raw values pass through in unsigned mode.
    always_comb begin
        mag_a_full = magnitude(MAG_MAX_W'(i_multiplicand),
                               i_signed_mode & i_multiplicand[WIDTH-1]);
        mag_b_full = magnitude(MAG_MAX_W'(i_multiplier),
                               i_signed_mode & i_multiplier[WIDTH-1]);
        {mag_a_unused, mag_a} = mag_a_full;
        {mag_b_unused, mag_b} = mag_b_full;
    end

    // Next-state of the shift registers and accumulator.
    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        if (i_load) begin
            mcand_d = PW'(mag_a);
            mplr_d  = mag_b;
            acc_d   = '0;
            neg_d   = i_signed_mode & (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
        end else if (i_step) begin
            acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
        end
    end

    // Flags that the multiplier will be exhausted after this step's shift,
    // so the controller can terminate early.
    assign o_mplr_zero = (mplr_q[WIDTH-1:1] == '0);

    // Sign-corrected accumulator, modulo 2^(2*WIDTH).
    assign o_result = neg_q ? ((~acc_q) + PW'(1)) : acc_q;

endmodule : seq_mult_datapath
`default_nettype wire

// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_unit
// Description : Radix-2 shift-add sequential multiplier with signed/unsigned
//               mode, start/ready/busy/done handshake and optional early
//               termination. Holds the product until the next operation.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Iteration counter width is derived from WIDTH and never overridden.
    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic            EARLY_EN = (EARLY_TERM != 0);

    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ready_q,   ready_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic                 load;
    logic                 step;
    logic                 mplr_zero;
    logic [2*WIDTH-1:0]   result;

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk            (clk),
        .rst            (reset),
        .i_load         (load),
        .i_step         (step),
        .i_signed_mode  (signed_mode),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_mplr_zero    (mplr_zero),
        .o_result       (result)
    );

    // Controller next-state, datapath strobes and next handshake outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                step    = 1'b1;
                count_d = count_q + CNT_W'(1);
                if ((count_q == LAST_CNT) || (EARLY_EN && mplr_zero)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                product_d = result;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered, so they are decoded from the next state.
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Controller registers; reset takes priority over a coincident start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_mult_unit
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_unit
// Description : Scoreboard bench for seq_mult_unit (WIDTH=16, EARLY_TERM=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

    localparam int WIDTH      = 16;
    localparam int EARLY_TERM = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    seq_mult_unit #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] prod;
        int          k;
        int          c0;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    bit          active   = 1'b0;
    int          cur_c0   = 0;
    int          cur_k    = 0;
    logic [31:0] cur_exp  = '0;
    logic [31:0] held_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint pa, pb, p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[31:0];
    endfunction

    // Reference iteration count: WIDTH, or highest set bit of |b| plus one.
    function automatic int ref_k(input logic [15:0] b, input logic s);
        int mag;
        int msb;
        if (EARLY_TERM == 0) return WIDTH;
        mag = (s && b[15]) ? (32'h10000 - int'(b)) : int'(b);
        msb = 0;
        for (int i = 0; i < 17; i++) if (((mag >> i) & 1) != 0) msb = i;
        return msb + 1;
    endfunction

    // Called at posedge+2; returns at posedge+2 of a cycle with ready=1.
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("ready_wait", ready, 1);
    endtask

    // Issue one operation and push its expected response.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        wait_ready();
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        start        = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        e.prod = ref_prod(a, b, s);
        e.k    = ref_k(b, s);
        e.c0   = cyc;
        held_exp = cur_exp;
        cur_exp  = e.prod;
        cur_k    = e.k;
        cur_c0   = e.c0;
        active   = 1'b1;
        sb_q.push_back(e);
    endtask

    // Monitor: per-cycle handshake/product checks and scoreboard pop on done.
    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_busy;
            logic        exp_done;
            logic [31:0] exp_p;
            exp_t        e;
            exp_busy = active && (cyc >= cur_c0) && (cyc <= cur_c0 + cur_k + 1);
            exp_done = active && (cyc == cur_c0 + cur_k + 1);
            exp_p    = (active && (cyc >= cur_c0 + cur_k + 1)) ? cur_exp : held_exp;
            check("busy",    busy,    exp_busy);
            check("ready",   ready,   !exp_busy);
            check("done",    done,    exp_done);
            check("product", product, exp_p);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_product", product, e.prod);
                    check("sb_latency", cyc - e.c0 + 1, e.k + 2);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        reset        = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ready",   ready,   1);
        check("reset_busy",    busy,    0);
        check("reset_done",    done,    0);
        check("reset_product", product, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed cases.
        issue(16'h0003, 16'h0005, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        issue(16'hFFFD, 16'h0007, 1'b1);
        issue(16'h8000, 16'h8000, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1);
        issue(16'hFFFF, 16'h8000, 1'b0);

        // Zero multiplier with starts pulsed during cycles 1..3.
        issue(16'h1234, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            multiplicand = 16'($urandom);
            multiplier   = 16'h00FF;
            signed_mode  = 1'b1;
            start        = 1'b1;
            @(posedge clk); #2;
        end
        start = 1'b0;
        repeat (4) begin @(posedge clk); #2; end

        // Reset asserted in ITER cycle 4 of a long operation.
        issue(16'h1234, 16'hFFFF, 1'b0);
        repeat (3) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        active   = 1'b0;
        cur_exp  = '0;
        held_exp = '0;
        sb_q.delete();
        check("midrst_ready",   ready,   1);
        check("midrst_busy",    busy,    0);
        check("midrst_done",    done,    0);
        check("midrst_product", product, 0);
        reset = 1'b0;
        issue(16'd7, 16'd6, 1'b0);

        // Randomized operations with varied multiplier magnitudes.
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            issue(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Drain and confirm every expected response was observed.
        wait_ready();
        repeat (3) begin @(posedge clk); #2; end
        check("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_mult_unit
`default_nettype wire
